// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    // Read data returned to a master whose transaction timed out.
    localparam int BUS_ERR_RDATA = 0;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin choice: on a tie the port not granted last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else begin
            gnt_idx = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one ready/valid memory bus between two masters, one transaction at a time,
// with a watchdog that completes unanswered requests with bus_err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_ready,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_valid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_ready,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_valid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_ready,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                bus_err
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t      state;
    logic            last_grant;
    logic [WD_W-1:0] wd;
    logic            gnt_valid;
    logic            gnt_idx;

    rr_pick2 u_pick (
        .req        ({m1_ready, m0_ready}),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wd         <= '0;
            s_ready    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_wstrb    <= '0;
            m0_valid   <= 1'b0;
            m1_valid   <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        last_grant <= gnt_idx;
                        s_addr     <= gnt_idx ? m1_addr  : m0_addr;
                        s_wdata    <= gnt_idx ? m1_wdata : m0_wdata;
                        s_wstrb    <= gnt_idx ? m1_wstrb : m0_wstrb;
                        s_ready    <= 1'b1;
                        wd         <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // A response landing on the expiry cycle still counts as a normal completion.
                    if (s_valid) begin
                        s_ready <= 1'b0;
                        if (last_grant) begin
                            m1_rdata <= s_rdata;
                            m1_valid <= 1'b1;
                        end else begin
                            m0_rdata <= s_rdata;
                            m0_valid <= 1'b1;
                        end
                        state <= RESP;
                    end else if (wd == WD_LAST) begin
                        s_ready <= 1'b0;
                        bus_err <= 1'b1;
                        if (last_grant) begin
                            m1_rdata <= DATA_W'(BUS_ERR_RDATA);
                            m1_valid <= 1'b1;
                        end else begin
                            m0_rdata <= DATA_W'(BUS_ERR_RDATA);
                            m0_valid <= 1'b1;
                        end
                        state <= RESP;
                    end else if (wd != '1) begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: begin
                    m0_valid <= 1'b0;
                    m1_valid <= 1'b0;
                    bus_err  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// a behavioural memory, and hand-computed expectations per scenario.
module tb_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        reset;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_ready;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_valid;
    logic [31:0] s_rdata;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_ready (m0_ready),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_wstrb (m0_wstrb),
        .m0_valid (m0_valid),
        .m0_rdata (m0_rdata),
        .m1_ready (m1_ready),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_wstrb (m1_wstrb),
        .m1_valid (m1_valid),
        .m1_rdata (m1_rdata),
        .s_ready  (s_ready),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_valid  (s_valid),
        .s_rdata  (s_rdata),
        .bus_err  (bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- memory: delay >= 0 answers after that many extra cycles, -1 never answers
    int          mem_delay = 0;
    bit          stray     = 1'b0;
    logic [31:0] mem [256];
    bit          pend;
    int          mcnt;
    int          wr_cnt  = 0;
    int          acc_cnt = 0;

    task automatic mem_op();
        s_valid <= 1'b1;
        s_rdata <= mem[s_addr[9:2]];
        if (s_wstrb != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (s_wstrb[b]) mem[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            wr_cnt <= wr_cnt + 1;
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            s_valid <= 1'b0;
            s_rdata <= '0;
            pend    <= 1'b0;
            mcnt    <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | i;
            mem[255] <= 32'h0000_002A;
        end else begin
            s_valid <= 1'b0;
            if (stray) begin
                s_valid <= 1'b1;
                s_rdata <= 32'hBAD0_BAD0;
            end else if (pend) begin
                if (mcnt == 0) begin
                    mem_op();
                    pend <= 1'b0;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end else if (s_ready && !s_valid && mem_delay >= 0) begin
                acc_cnt <= acc_cnt + 1;
                if (mem_delay == 0) begin
                    mem_op();
                end else begin
                    pend <= 1'b1;
                    mcnt <= mem_delay - 1;
                end
            end
        end
    end

    // ---------------- reference model: one outstanding transaction, owner chosen by the tie rule
    bit          model_on = 1'b0;
    logic        e_sready, e_v0, e_v1, e_err, e_resp, e_last, e_owner;
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
    logic [3:0]  e_wstrb;
    int          e_waited;
    logic        m_win;

    always_comb m_win = (m0_ready && m1_ready) ? !e_last : m1_ready;

    always @(posedge clk) begin
        if (!reset) begin
            model_on <= 1'b1;
            e_sready <= 1'b0; e_v0 <= 1'b0; e_v1 <= 1'b0; e_err <= 1'b0; e_resp <= 1'b0;
            e_last <= 1'b1; e_owner <= 1'b0;
            e_addr <= '0; e_wdata <= '0; e_wstrb <= '0; e_rd0 <= '0; e_rd1 <= '0;
            e_waited <= 0;
        end else if (e_resp) begin
            e_resp <= 1'b0; e_v0 <= 1'b0; e_v1 <= 1'b0; e_err <= 1'b0;
        end else if (e_sready) begin
            if (s_valid || e_waited == TIMEOUT - 1) begin
                e_sready <= 1'b0;
                e_resp   <= 1'b1;
                e_err    <= !s_valid;
                if (e_owner) begin
                    e_v1  <= 1'b1;
                    e_rd1 <= s_valid ? s_rdata : 32'h0;
                end else begin
                    e_v0  <= 1'b1;
                    e_rd0 <= s_valid ? s_rdata : 32'h0;
                end
            end else begin
                e_waited <= e_waited + 1;
            end
        end else if (m0_ready || m1_ready) begin
            e_owner  <= m_win;
            e_last   <= m_win;
            e_addr   <= m_win ? m1_addr  : m0_addr;
            e_wdata  <= m_win ? m1_wdata : m0_wdata;
            e_wstrb  <= m_win ? m1_wstrb : m0_wstrb;
            e_sready <= 1'b1;
            e_waited <= 0;
        end
    end

    // ---------------- per-cycle compare and pulse/ready monitors
    int vq_port[$];
    int vq_cyc[$];
    int sready_cnt = 0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("s_ready",  s_ready,  e_sready);
            chk("s_addr",   s_addr,   e_addr);
            chk("s_wdata",  s_wdata,  e_wdata);
            chk("s_wstrb",  s_wstrb,  e_wstrb);
            chk("m0_valid", m0_valid, e_v0);
            chk("m1_valid", m1_valid, e_v1);
            chk("m0_rdata", m0_rdata, e_rd0);
            chk("m1_rdata", m1_rdata, e_rd1);
            chk("bus_err",  bus_err,  e_err);
        end
        if (m0_valid) begin vq_port.push_back(0); vq_cyc.push_back(cyc); end
        if (m1_valid) begin vq_port.push_back(1); vq_cyc.push_back(cyc); end
        if (s_ready) sready_cnt <= sready_cnt + 1;
    end

    // ---------------- stimulus helpers
    task automatic drive(input int p, input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        if (p == 0) begin m0_ready = r; m0_addr = a; m0_wdata = d; m0_wstrb = s; end
        else        begin m1_ready = r; m1_addr = a; m1_wdata = d; m1_wstrb = s; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Issues n requests back to back; reports data/err/latency of the last one.
    task automatic master(input int p, input int n, input logic [31:0] a0, input logic [31:0] d0,
                          input logic [3:0] s, output logic [31:0] rd, output logic err,
                          output int lat);
        bit got;
        rd = '0; err = 1'b0; lat = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive(p, 1'b1, a0 + 32'(4 * k), d0 + 32'(k), s);
            got = 1'b0;
            lat = 0;
            for (int t = 0; t < 60 && !got; t++) begin
                @(negedge clk);
                lat++;
                if (p == 0 ? m0_valid : m1_valid) begin
                    got = 1'b1;
                    rd  = (p == 0) ? m0_rdata : m1_rdata;
                    err = bus_err;
                end
            end
            if (!got) chk("completion_wait", 0, 1);
        end
        @(negedge clk);
        drive(p, 1'b0, '0, '0, '0);
    endtask

    logic [31:0] rd0, rd1;
    logic        er0, er1;
    int          l0, l1, q0, sr0, w0, a0;

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        chk("reset_s_ready", s_ready, 0);
        chk("reset_m0_valid", m0_valid, 0);
        reset = 1'b1;

        // Single read, zero-wait memory
        mem_delay = 0;
        q0 = vq_port.size(); sr0 = sready_cnt; a0 = acc_cnt;
        master(0, 1, 32'h3FC, 32'h0, 4'h0, rd0, er0, l0);
        chk("single_rdata", rd0, 32'h2A);
        chk("single_latency", l0, 3);
        chk("single_err", er0, 0);
        chk("single_sready_cycles", sready_cnt - sr0, 2);
        chk("single_mem_accepts", acc_cnt - a0, 1);
        chk("single_pulses", vq_port.size() - q0, 1);
        chk("single_port", vq_port[q0], 0);

        // Tie at reset release, two writes
        do_reset();
        q0 = vq_port.size(); w0 = wr_cnt;
        fork
            master(0, 1, 32'h100, 32'h11, 4'hF, rd0, er0, l0);
            master(1, 1, 32'h104, 32'h22, 4'hF, rd1, er1, l1);
        join
        chk("tie_first_port", vq_port[q0], 0);
        chk("tie_second_port", vq_port[q0+1], 1);
        chk("tie_mem_0x100", mem[64], 32'h11);
        chk("tie_mem_0x104", mem[65], 32'h22);
        chk("tie_write_count", wr_cnt - w0, 2);

        // Sustained contention, 4 reads per master
        do_reset();
        q0 = vq_port.size();
        fork
            master(0, 4, 32'h000, 32'h0, 4'h0, rd0, er0, l0);
            master(1, 4, 32'h200, 32'h0, 4'h0, rd1, er1, l1);
        join
        chk("sustain_pulses", vq_port.size() - q0, 8);
        for (int i = 0; i < 8; i++) begin
            chk("sustain_order", vq_port[q0+i], i % 2);
            if (i > 0) chk("sustain_spacing", vq_cyc[q0+i] - vq_cyc[q0+i-1], 4);
        end
        chk("sustain_m0_last", rd0, 32'hC0DE_0003);
        chk("sustain_m1_last", rd1, 32'hC0DE_0083);

        // Timeout on m1, then a stray response while idle
        do_reset();
        mem_delay = -1;
        sr0 = sready_cnt; q0 = vq_port.size();
        master(1, 1, 32'h40, 32'h0, 4'h0, rd1, er1, l1);
        chk("timeout_err", er1, 1);
        chk("timeout_rdata", rd1, 32'h0);
        chk("timeout_latency", l1, 16);
        chk("timeout_sready_cycles", sready_cnt - sr0, 15);
        q0 = vq_port.size();
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_no_pulse", vq_port.size() - q0, 0);
        chk("stray_m1_rdata_held", m1_rdata, 32'h0);

        // Reset while BUSY
        @(negedge clk);
        drive(0, 1'b1, 32'h80, 32'h5, 4'h0);
        repeat (5) @(negedge clk);
        chk("midrst_busy", s_ready, 1);
        reset = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        chk("midrst_outputs", {s_ready, m0_valid, m1_valid, bus_err, s_wstrb}, 8'h0);
        chk("midrst_addr", s_addr, 32'h0);
        chk("midrst_rdata", {m0_rdata, m1_rdata}, 64'h0);
        reset = 1'b1;
        mem_delay = 0;
        q0 = vq_port.size();
        fork
            master(0, 1, 32'h8, 32'h0, 4'h0, rd0, er0, l0);
            master(1, 1, 32'hC, 32'h0, 4'h0, rd1, er1, l1);
        join
        chk("midrst_tie_first", vq_port[q0], 0);
        chk("midrst_m1_data", rd1, 32'hC0DE_0003);

        // Response on the watchdog expiry cycle
        do_reset();
        mem_delay = 13;
        master(0, 1, 32'h10, 32'h0, 4'h0, rd0, er0, l0);
        chk("race_rdata", rd0, 32'hC0DE_0004);
        chk("race_err", er0, 0);
        chk("race_latency", l0, 16);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
